// File: rtl/block_hadamard_stream.sv
// Streaming 2-D Walsh-Hadamard transform (Y = H*X*H^T) on NxN blocks: load, row pass, column pass, drain.
// Optional macro BLOCK_HADAMARD_SCALE_EN rounds and scales the output by 1/N (half up).
module block_hadamard_stream #(
   parameter int N = 8,
   parameter int IN_W = 9,
   localparam int LG = $clog2(N),
`ifdef BLOCK_HADAMARD_SCALE_EN
   localparam int OUT_W = IN_W + LG
`else
   localparam int OUT_W = IN_W + 2*LG
`endif
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic signed [IN_W-1:0]  in_data,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic signed [OUT_W-1:0] out_data,
   output logic                    out_last,
   output logic                    busy
);

   localparam int FW = IN_W + 2*LG;
   localparam int CW = 2*LG;

   typedef enum logic [1:0] {LOAD, ROW, COL, OUT} state_e;

   state_e               state_q, state_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic signed [FW-1:0] buf_q [N*N];
   logic signed [FW-1:0] vec [N];
   logic [LG-1:0]        line;

   assign line = cnt_q[LG-1:0];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= LOAD;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // cnt doubles as the sample index in LOAD/OUT and as the row/column index in ROW/COL.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         LOAD: begin
            if (in_valid) begin
               if (cnt_q == CW'(N*N-1)) begin
                  state_d = ROW;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end
         ROW: begin
            if (cnt_q == CW'(N-1)) begin
               state_d = COL;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         COL: begin
            if (cnt_q == CW'(N-1)) begin
               state_d = OUT;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         OUT: begin
            if (out_ready) begin
               if (cnt_q == CW'(N*N-1)) begin
                  state_d = LOAD;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end
         default: begin
            state_d = LOAD;
            cnt_d   = '0;
         end
      endcase
   end

   // Fast Walsh-Hadamard butterflies over one row or column; this ordering yields Sylvester natural order.
   always_comb begin
      logic [LG-1:0]        lo;
      logic [LG-1:0]        hi;
      logic signed [FW-1:0] a;
      lo = '0;
      hi = '0;
      a  = '0;
      for (int i = 0; i < N; i++) begin
         vec[i] = (state_q == COL) ? buf_q[{LG'(i), line}] : buf_q[{line, LG'(i)}];
      end
      for (int s = 0; s < LG; s++) begin
         for (int p = 0; p < N/2; p++) begin
            lo = LG'(((p >> s) << (s+1)) + (p & ((1 << s) - 1)));
            hi = lo + LG'(1 << s);
            a       = vec[lo];
            vec[lo] = a + vec[hi];
            vec[hi] = a - vec[hi];
         end
      end
   end

   // Block buffer is never reset; a fresh block always overwrites every entry before it is read.
   always_ff @(posedge clk) begin
      case (state_q)
         LOAD: begin
            if (in_valid) begin
               buf_q[cnt_q] <= {{(FW-IN_W){in_data[IN_W-1]}}, in_data};
            end
         end
         ROW: begin
            for (int i = 0; i < N; i++) begin
               buf_q[{line, LG'(i)}] <= vec[i];
            end
         end
         COL: begin
            for (int i = 0; i < N; i++) begin
               buf_q[{LG'(i), line}] <= vec[i];
            end
         end
         default: begin
         end
      endcase
   end

   assign in_ready  = (state_q == LOAD);
   assign out_valid = (state_q == OUT);
   assign busy      = (state_q != LOAD);
   assign out_last  = (state_q == OUT) && (cnt_q == CW'(N*N-1));

`ifdef BLOCK_HADAMARD_SCALE_EN
   // Headroom of the full-width buffer guarantees the rounding offset cannot overflow.
   assign out_data = (state_q == OUT) ? OUT_W'((buf_q[cnt_q] + FW'(N/2)) >>> LG) : '0;
`else
   assign out_data = (state_q == OUT) ? buf_q[cnt_q] : '0;
`endif

endmodule

// File: tb/tb_block_hadamard_stream.sv
// Directed, table-driven bench for block_hadamard_stream (N=8, IN_W=9), with hand-written
// sequences for backpressure, a partial-block pause and reset during the column pass.
module tb_block_hadamard_stream;

   localparam int N = 8;
   localparam int IN_W = 9;
`ifdef BLOCK_HADAMARD_SCALE_EN
   localparam int OUT_W = IN_W + 3;
`else
   localparam int OUT_W = IN_W + 6;
`endif

   typedef struct {
      string name;
      int    kind;
      int    val;
      int    expA;
      int    expB;
      int    stallAt;
   } vec_t;

   logic                    clk;
   logic                    rst_n;
   logic                    inValid;
   logic                    inReady;
   logic signed [IN_W-1:0]  inData;
   logic                    outValid;
   logic                    outReady;
   logic signed [OUT_W-1:0] outData;
   logic                    outLast;
   logic                    busy;

   int assertCount;
   int failCount;
   vec_t vectors [5];

   block_hadamard_stream #(.N(N), .IN_W(IN_W)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_valid (inValid),
      .in_ready (inReady),
      .in_data  (inData),
      .out_valid(outValid),
      .out_ready(outReady),
      .out_data (outData),
      .out_last (outLast),
      .busy     (busy)
   );

   // 10 ns clock; inputs change and outputs are sampled on the falling edge.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic checkOutput(input string name, input int actual, input int expected);
      assertCount++;
      if (actual != expected) begin
         failCount++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
      end
   endtask

   function automatic int sampleOf(input int kind, input int val, input int idx);
      case (kind)
         0:       return val;
         1:       return (idx == 0) ? val : 0;
         default: return (idx == 1) ? val : 0;
      endcase
   endfunction

   // kind 0: constant block (DC term then zeros); kind 1: X[0][0] impulse (flat);
   // kind 2: X[0][1] impulse (sign alternates with column parity).
   function automatic int expectedOf(input vec_t v, input int idx);
      case (v.kind)
         0:       return (idx == 0) ? v.expA : v.expB;
         1:       return v.expA;
         default: return ((idx % N) % 2 == 0) ? v.expA : v.expB;
      endcase
   endfunction

   // Feeds samples first..last of a block, one per cycle.
   task automatic applyStimulus(input int kind, input int val, input int first, input int last);
      for (int i = first; i <= last; i++) begin
         @(negedge clk);
         if (!inReady) checkOutput($sformatf("in_ready_load[%0d]", i), int'(inReady), 1);
         inValid = 1'b1;
         inData  = IN_W'(sampleOf(kind, val, i));
         @(posedge clk);
      end
   endtask

   // Keeps in_valid high with junk during ROW/COL to prove it is ignored; measures latency.
   task automatic waitLatency(input string name);
      int k;
      k = 1;
      @(negedge clk);
      while (!outValid && k < 60) begin
         inValid = 1'b1;
         inData  = IN_W'(77);
         checkOutput($sformatf("%s in_ready_busy", name), int'(inReady), 0);
         checkOutput($sformatf("%s busy", name), int'(busy), 1);
         k++;
         @(negedge clk);
      end
      inValid = 1'b0;
      checkOutput($sformatf("%s latency", name), k, 2*N+1);
   endtask

   task automatic drainBlock(input vec_t v);
      for (int idx = 0; idx < N*N; idx++) begin
         if (idx == v.stallAt) begin
            outReady = 1'b0;
            for (int s = 0; s < 10; s++) begin
               checkOutput($sformatf("%s stall data", v.name), int'(outData), expectedOf(v, idx));
               checkOutput($sformatf("%s stall last", v.name), int'(outLast), 0);
               checkOutput($sformatf("%s stall in_ready", v.name), int'(inReady), 0);
               checkOutput($sformatf("%s stall valid", v.name), int'(outValid), 1);
               @(negedge clk);
            end
         end
         outReady = 1'b1;
         checkOutput($sformatf("%s valid[%0d]", v.name, idx), int'(outValid), 1);
         checkOutput($sformatf("%s data[%0d]", v.name, idx), int'(outData), expectedOf(v, idx));
         checkOutput($sformatf("%s last[%0d]", v.name, idx), int'(outLast), (idx == N*N-1) ? 1 : 0);
         @(negedge clk);
      end
      outReady = 1'b0;
      checkOutput($sformatf("%s post in_ready", v.name), int'(inReady), 1);
      checkOutput($sformatf("%s post out_valid", v.name), int'(outValid), 0);
      checkOutput($sformatf("%s post busy", v.name), int'(busy), 0);
   endtask

   task automatic checkResetOutputs(input string name);
      checkOutput($sformatf("%s in_ready", name), int'(inReady), 1);
      checkOutput($sformatf("%s out_valid", name), int'(outValid), 0);
      checkOutput($sformatf("%s out_last", name), int'(outLast), 0);
      checkOutput($sformatf("%s out_data", name), int'(outData), 0);
      checkOutput($sformatf("%s busy", name), int'(busy), 0);
   endtask

   initial begin
      vec_t extra;
      assertCount = 0;
      failCount   = 0;
      rst_n       = 1'b0;
      inValid     = 1'b0;
      inData      = '0;
      outReady    = 1'b0;

`ifdef BLOCK_HADAMARD_SCALE_EN
      vectors[0] = '{"ones",     0,    1,     8,  0, 20};
      vectors[1] = '{"impulse5", 1,    5,     1,  1, -1};
      vectors[2] = '{"impX01",   2,    1,     0,  0, -1};
      vectors[3] = '{"minus256", 0, -256, -2048,  0, -1};
      vectors[4] = '{"threes",   0,    3,    24,  0, -1};
`else
      vectors[0] = '{"ones",     0,    1,     64,  0, 20};
      vectors[1] = '{"impulse5", 1,    5,      5,  5, -1};
      vectors[2] = '{"impX01",   2,    1,      1, -1, -1};
      vectors[3] = '{"minus256", 0, -256, -16384,  0, -1};
      vectors[4] = '{"threes",   0,    3,    192,  0, -1};
`endif

      #3;
      checkResetOutputs("reset");
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      checkResetOutputs("after_release");

      foreach (vectors[v]) begin
         applyStimulus(vectors[v].kind, vectors[v].val, 0, N*N-1);
         waitLatency(vectors[v].name);
         drainBlock(vectors[v]);
      end

      // Partial block pauses indefinitely in LOAD, then completes normally.
      extra = vectors[4];
      extra.name = "paused";
      applyStimulus(extra.kind, extra.val, 0, 9);
      @(negedge clk);
      inValid = 1'b0;
      repeat (30) @(negedge clk);
      checkOutput("paused in_ready", int'(inReady), 1);
      checkOutput("paused busy", int'(busy), 0);
      checkOutput("paused out_valid", int'(outValid), 0);
      applyStimulus(extra.kind, extra.val, 10, N*N-1);
      waitLatency(extra.name);
      drainBlock(extra);

      // Reset during the column pass discards the block; the next block starts at index 0.
      applyStimulus(0, 1, 0, N*N-1);
      @(negedge clk);
      inValid = 1'b0;
      repeat (N+1) @(negedge clk);
      checkOutput("col busy", int'(busy), 1);
      rst_n = 1'b0;
      #1;
      checkResetOutputs("reset_in_col");
      @(negedge clk);
      rst_n = 1'b1;
      extra.name = "twos";
      extra.kind = 0;
      extra.val  = 2;
`ifdef BLOCK_HADAMARD_SCALE_EN
      extra.expA = 16;
`else
      extra.expA = 128;
`endif
      extra.expB = 0;
      extra.stallAt = -1;
      applyStimulus(extra.kind, extra.val, 0, N*N-1);
      waitLatency(extra.name);
      drainBlock(extra);

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
